// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction-fetch stage: PC register, imem req/ack fetch FSM, next-PC select
// Fetches one word at a time, holds it on ins until retired, then steps to PC+4, beq target or j target.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic        ins_valid,
  input  logic        ins_ready,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] pc,
  output logic        fetch_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {S_RST, S_FETCH, S_ISSUE} state_t;

  state_t         state, stateNext;
  logic [CW-1:0]  waitCnt, waitCntNext;
  logic [31:0]    pcNext, insNext, pc4, branchOff, targetPc;
  logic           insValidNext, reqNext, errNext;

  assign imem_addr = pc;

  // Target select: jump has priority over a taken branch.
  assign pc4       = pc + 32'd4;
  assign branchOff = {{14{ins[15]}}, ins[15:0], 2'b00};
  always_comb begin
    targetPc = pc4;
    if (jump)
      targetPc = {pc4[31:28], ins[25:0], 2'b00};
    else if (branch && zero)
      targetPc = pc4 + branchOff;
  end

  always_comb begin
    stateNext    = state;
    waitCntNext  = waitCnt;
    pcNext       = pc;
    insNext      = ins;
    insValidNext = ins_valid;
    reqNext      = imem_req;
    errNext      = fetch_err;
    case (state)
      S_RST: begin
        stateNext = S_FETCH;
        reqNext   = 1'b1;
      end
      S_FETCH: begin
        reqNext = 1'b1;
        if (imem_ack) begin
          insNext      = imem_rdata;
          insValidNext = 1'b1;
          reqNext      = 1'b0;
          waitCntNext  = '0;
          stateNext    = S_ISSUE;
        end else if (waitCnt == CW'(TIMEOUT - 1)) begin
          // Flag the stall but keep the request up so memory can still answer.
          errNext     = 1'b1;
          waitCntNext = '0;
        end else begin
          waitCntNext = waitCnt + CW'(1);
        end
      end
      S_ISSUE: begin
        if (ins_ready && ins_valid) begin
          insValidNext = 1'b0;
          pcNext       = targetPc;
          reqNext      = 1'b1;
          stateNext    = S_FETCH;
        end
      end
      default: stateNext = S_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RST;
      waitCnt   <= '0;
      pc        <= RESET_PC_ALIGNED;
      ins       <= '0;
      ins_valid <= 1'b0;
      imem_req  <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      state     <= stateNext;
      waitCnt   <= waitCntNext;
      pc        <= pcNext;
      ins       <= insNext;
      ins_valid <= insValidNext;
      imem_req  <= reqNext;
      fetch_err <= errNext;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - self-checking bench for ifetch_unit with a next-PC reference model
// Memory responses and decoder flags are driven per instruction; expected PC comes from plain arithmetic.
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          TIMEOUT  = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ins;
  logic        ins_valid;
  logic        ins_ready;
  logic        branch;
  logic        jump;
  logic        zero;
  logic [31:0] pc;
  logic        fetch_err;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] expPc;
  logic        expErr;

  ifetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ins(ins), .ins_valid(ins_valid),
    .ins_ready(ins_ready), .branch(branch), .jump(jump), .zero(zero),
    .pc(pc), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] modelNextPc(input logic [31:0] p, input logic [31:0] w,
                                               input logic br, input logic jp, input logic zr);
    logic [31:0] p4;
    int          off;
    p4 = p + 32'd4;
    if (jp) return (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    if (br && zr) begin
      off = $signed(w[15:0]);
      return p4 + 32'(off * 4);
    end
    return p4;
  endfunction

  task automatic waitReq(input string name);
    int n = 0;
    while (imem_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (imem_req !== 1'b1) begin
      failures++;
      $display("FAIL %s_req_wait: imem_req=%b required 1", name, imem_req);
    end
  endtask

  task automatic checkResetValues(input string name);
    checks++;
    if (ins !== 32'h0 || ins_valid !== 1'b0 || imem_req !== 1'b0 ||
        fetch_err !== 1'b0 || pc !== RESET_PC) begin
      failures++;
      $display("FAIL %s: ins=%h valid=%b req=%b err=%b pc=%h required 0/0/0/0/%h",
               name, ins, ins_valid, imem_req, fetch_err, pc, RESET_PC);
    end
  endtask

  // One complete fetch (ack after lat idle cycles) followed by retirement with the given flags.
  task automatic fetchRetire(input logic [31:0] word, input int lat,
                             input logic br, input logic jp, input logic zr);
    int hold;
    waitReq("fetch");
    checks++;
    if (imem_addr !== expPc) begin
      failures++;
      $display("FAIL fetch_addr: imem_addr=%h required %h", imem_addr, expPc);
    end
    for (int i = 0; i < lat; i++) begin
      ins_ready = 1'($urandom);
      branch    = 1'($urandom);
      jump      = 1'($urandom);
      zero      = 1'($urandom);
      @(negedge clk);
    end
    ins_ready  = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    checks++;
    if (ins_valid !== 1'b1 || ins !== word || pc !== expPc || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL fetch_load: valid=%b ins=%h pc=%h req=%b required 1/%h/%h/0",
               ins_valid, ins, pc, imem_req, word, expPc);
    end
    checks++;
    if (fetch_err !== expErr) begin
      failures++;
      $display("FAIL fetch_err_state: fetch_err=%b required %b", fetch_err, expErr);
    end
    hold = $urandom_range(0, 3);
    for (int i = 0; i < hold; i++) begin
      branch     = 1'($urandom);
      jump       = 1'($urandom);
      zero       = 1'($urandom);
      imem_ack   = 1'($urandom);
      @(negedge clk);
      imem_ack   = 1'b0;
      checks++;
      if (ins !== word || ins_valid !== 1'b1 || pc !== expPc || imem_req !== 1'b0) begin
        failures++;
        $display("FAIL issue_hold: ins=%h valid=%b pc=%h req=%b required %h/1/%h/0",
                 ins, ins_valid, pc, imem_req, word, expPc);
      end
    end
    branch    = br;
    jump      = jp;
    zero      = zr;
    ins_ready = 1'b1;
    @(negedge clk);
    ins_ready = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    zero      = 1'b0;
    expPc     = modelNextPc(expPc, word, br, jp, zr);
    checks++;
    if (ins_valid !== 1'b0 || imem_req !== 1'b1 || pc !== expPc) begin
      failures++;
      $display("FAIL retire: valid=%b req=%b pc=%h required 0/1/%h", ins_valid, imem_req, pc, expPc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("reset_values");
    rst_n  = 1'b1;
    expPc  = RESET_PC;
    expErr = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      failures++;
      $display("FAIL reset_first_req: req=%b addr=%h required 1/%h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_basic();
    fetchRetire(32'h8C01_0004, 2, 1'b0, 1'b0, 1'b0);
    checks++;
    if (imem_addr !== 32'h0000_0004) begin
      failures++;
      $display("FAIL basic_next_addr: imem_addr=%h required 00000004", imem_addr);
    end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 3; i++) fetchRetire($urandom, $urandom_range(0, 4), 1'b0, 1'b0, 1'b1);
    fetchRetire(32'h1022_FFFC, 1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (pc !== 32'h0000_0004) begin
      failures++;
      $display("FAIL branch_taken: pc=%h required 00000004", pc);
    end
    for (int i = 0; i < 3; i++) fetchRetire($urandom, $urandom_range(0, 4), 1'b1, 1'b0, 1'b0);
    fetchRetire(32'h1022_FFFC, 0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pc !== 32'h0000_0014) begin
      failures++;
      $display("FAIL branch_not_taken: pc=%h required 00000014", pc);
    end
  endtask

  task automatic test_wrap();
    // From 0x14, offset -7 words lands on the last word of the address space.
    fetchRetire(32'h1000_FFF9, 1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (pc !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_setup: pc=%h required fffffffc", pc);
    end
    fetchRetire($urandom, 2, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pc !== 32'h0000_0000) begin
      failures++;
      $display("FAIL wrap_around: pc=%h required 00000000", pc);
    end
  endtask

  task automatic test_jump();
    // Climb regions: jump to the last word of a 256MB region, then step across it.
    for (int r = 0; r < 4; r++) begin
      fetchRetire(32'h0BFF_FFFF, 1, 1'b0, 1'b1, 1'b0);
      fetchRetire($urandom, 0, 1'b0, 1'b0, 1'b0);
    end
    fetchRetire($urandom, 1, 1'b0, 1'b0, 1'b0);
    fetchRetire($urandom, 1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pc !== 32'h4000_0008) begin
      failures++;
      $display("FAIL jump_setup: pc=%h required 40000008", pc);
    end
    fetchRetire(32'h0800_0010, 2, 1'b1, 1'b1, 1'b1);
    checks++;
    if (pc !== 32'h4000_0040) begin
      failures++;
      $display("FAIL jump_priority: pc=%h required 40000040", pc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++)
      fetchRetire($urandom, $urandom_range(0, 6), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic test_timeout();
    waitReq("timeout");
    for (int i = 1; i <= TIMEOUT + 3; i++) begin
      @(negedge clk);
      checks++;
      if (fetch_err !== (i >= TIMEOUT)) begin
        failures++;
        $display("FAIL timeout_err cycle %0d: fetch_err=%b required %b", i, fetch_err, (i >= TIMEOUT));
      end
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== expPc) begin
        failures++;
        $display("FAIL timeout_retry cycle %0d: req=%b addr=%h required 1/%h", i, imem_req, imem_addr, expPc);
      end
    end
    expErr = 1'b1;
    fetchRetire($urandom, 0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (fetch_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky: fetch_err=%b required 1", fetch_err);
    end
  endtask

  task automatic test_reset_mid_fetch();
    waitReq("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetValues("midreset_async");
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack   = 1'b0;
    checkResetValues("midreset_ack_ignored");
    rst_n  = 1'b1;
    expPc  = RESET_PC;
    expErr = 1'b0;
    fetchRetire(32'h8C01_0004, 1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    ins_ready  = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    zero       = 1'b0;
    expPc      = RESET_PC;
    expErr     = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_branch();
    test_wrap();
    test_jump();
    test_random();
    test_timeout();
    test_reset_mid_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
